// File: rtl/spi_transfer_engine_if.sv
// Bundle of signals between the SPI transfer engine and its surroundings:
// the start/data handshake on one side and the board-level SPI pins on the other.
interface spi_transfer_engine_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  spi_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  spi_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  spi_cs_n;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_miso;

  // master is everything around the engine: the start generator and the SPI device's MISO pin.
  modport master (
    output spi_start, tx_data, spi_miso,
    input  spi_ready, rx_data, rx_valid, spi_cs_n, spi_sclk, spi_mosi
  );

  modport slave (
    input  spi_start, tx_data, spi_miso,
    output spi_ready, rx_data, rx_valid, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_transfer_engine.sv
// SPI mode-0 controller shift engine: one full-duplex word per accepted spi_start pulse.
// Optional build macro SPI_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
module spi_transfer_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rstn,
  spi_transfer_engine_if.slave bus
);

  localparam int                BIT_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } state_e;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w);
    return w >> 1;
  endfunction

  // First received bit ends up in bit 0 after DATA_WIDTH shifts.
  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return {b, w[DATA_WIDTH-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w);
    return w << 1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return {w[DATA_WIDTH-2:0], b};
  endfunction
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  ready_q, ready_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  div_last;
  logic [DATA_WIDTH-1:0] tx_next;

  assign div_last = (div_q == DIV_LAST);
  assign tx_next  = tx_shift(tx_sh_q);

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    ready_d    = ready_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Acceptance keys off the registered ready, so a start on the completion edge is dropped.
        if (bus.spi_start && ready_q) begin
          tx_sh_d = bus.tx_data;
          mosi_d  = first_bit(bus.tx_data);
          rx_sh_d = '0;
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = CS_SETUP;
        end
      end

      CS_SETUP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_sh_d = rx_shift(rx_sh_q, bus.spi_miso);
          end else begin
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = CS_HOLD;
            end else begin
              tx_sh_d = tx_next;
              mosi_d  = first_bit(tx_next);
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      CS_HOLD: begin
        if (div_last) begin
          div_d      = '0;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          ready_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      ready_q    <= 1'b1;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      ready_q    <= ready_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus.spi_ready = ready_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_transfer_engine.sv
// Directed bench for spi_transfer_engine at DATA_WIDTH=16, CLK_DIV=4.
// Outputs are sampled on the falling clock edge; stimulus changes there too.
module tb_spi_transfer_engine;

  logic clk;
  logic rstn;
  logic miso_loop;
  logic miso_fixed;

  int n_checks = 0;
  int n_pass   = 0;

  spi_transfer_engine_if #(.DATA_WIDTH(16)) bus ();

  assign bus.spi_miso = miso_loop ? bus.spi_mosi : miso_fixed;

  spi_transfer_engine #(
    .DATA_WIDTH(16),
    .CLK_DIV   (4),
    .CNT_W     (8)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SPI_LSB_FIRST_EN
  localparam logic [15:0] SEQ_A5C3 = 16'hC3A5;
  localparam logic [15:0] SEQ_1234 = 16'h2C48;
  localparam logic [15:0] SEQ_0001 = 16'h8000;
`else
  localparam logic [15:0] SEQ_A5C3 = 16'hA5C3;
  localparam logic [15:0] SEQ_1234 = 16'h1234;
  localparam logic [15:0] SEQ_0001 = 16'h0001;
`endif

  // Results of the most recent run_xfer window.
  int          r_ready_low;
  int          r_cs_low;
  int          r_rises;
  int          r_valid_cnt;
  int          r_mosi_ones;
  int          r_setup_gap;
  int          r_hold_gap;
  logic [15:0] r_seq;
  logic [15:0] r_rx;

  // One start pulse, then a fixed 170-cycle observation window starting the cycle after acceptance.
  task automatic run_xfer(input logic [15:0] tx, input bit inject);
    logic prev_sclk;
    int   first_cs, last_cs, first_rise, last_fall;
    r_ready_low = 0; r_cs_low = 0; r_rises = 0; r_valid_cnt = 0; r_mosi_ones = 0;
    r_seq = '0; r_rx = '0;
    first_cs = -1; last_cs = -1; first_rise = -1; last_fall = -1;
    prev_sclk = 1'b0;
    @(negedge clk);
    bus.spi_start = 1'b1;
    bus.tx_data   = tx;
    @(negedge clk);
    bus.spi_start = 1'b0;
    bus.tx_data   = ~tx;
    for (int idx = 1; idx <= 170; idx++) begin
      if (idx > 1) @(negedge clk);
      if (!bus.spi_ready) r_ready_low++;
      if (!bus.spi_cs_n) begin
        r_cs_low++;
        if (first_cs < 0) first_cs = idx;
        last_cs = idx;
        if (bus.spi_mosi) r_mosi_ones++;
      end
      if (bus.spi_sclk && !prev_sclk) begin
        r_rises++;
        r_seq = {r_seq[14:0], bus.spi_mosi};
        if (first_rise < 0) first_rise = idx;
      end
      if (!bus.spi_sclk && prev_sclk) last_fall = idx;
      prev_sclk = bus.spi_sclk;
      if (bus.rx_valid) begin
        r_valid_cnt++;
        r_rx = bus.rx_data;
      end
      if (inject && (idx == 10 || idx == 60 || idx == 136)) begin
        bus.spi_start = 1'b1;
        bus.tx_data   = 16'h5A5A;
      end else begin
        bus.spi_start = 1'b0;
      end
    end
    r_setup_gap = first_rise - first_cs;
    r_hold_gap  = last_cs + 1 - last_fall;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.spi_start = 1'b0;
    bus.tx_data   = '0;
    miso_loop  = 1'b1;
    miso_fixed = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.spi_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.spi_ready);
    else n_pass++;
    n_checks++;
    if (bus.spi_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", bus.spi_cs_n);
    else n_pass++;
    n_checks++;
    if (bus.spi_sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", bus.spi_sclk);
    else n_pass++;
    n_checks++;
    if (bus.spi_mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", bus.spi_mosi);
    else n_pass++;
    n_checks++;
    if (bus.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid);
    else n_pass++;
    n_checks++;
    if (bus.rx_data !== 16'h0000) $display("FAIL reset_rx_data: got %h want 0000", bus.rx_data);
    else n_pass++;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.spi_ready !== 1'b1 || bus.spi_cs_n !== 1'b1)
      $display("FAIL post_reset_idle: got ready=%b cs_n=%b want 1/1", bus.spi_ready, bus.spi_cs_n);
    else n_pass++;
  endtask

  task automatic test_loopback();
    miso_loop = 1'b1;
    run_xfer(16'hA5C3, 1'b0);
    n_checks++;
    if (r_rises !== 16) $display("FAIL loop_rises: got %0d want 16", r_rises);
    else n_pass++;
    n_checks++;
    if (r_seq !== SEQ_A5C3) $display("FAIL loop_mosi_seq: got %h want %h", r_seq, SEQ_A5C3);
    else n_pass++;
    n_checks++;
    if (r_rx !== 16'hA5C3) $display("FAIL loop_rx_data: got %h want a5c3", r_rx);
    else n_pass++;
    n_checks++;
    if (r_valid_cnt !== 1) $display("FAIL loop_valid_count: got %0d want 1", r_valid_cnt);
    else n_pass++;
    n_checks++;
    if (r_ready_low !== 136) $display("FAIL loop_ready_low: got %0d want 136", r_ready_low);
    else n_pass++;
    n_checks++;
    if (bus.rx_data !== 16'hA5C3) $display("FAIL loop_rx_held: got %h want a5c3", bus.rx_data);
    else n_pass++;
  endtask

  task automatic test_miso_high();
    miso_loop  = 1'b0;
    miso_fixed = 1'b1;
    run_xfer(16'h0000, 1'b0);
    n_checks++;
    if (r_rx !== 16'hFFFF) $display("FAIL high_rx_data: got %h want ffff", r_rx);
    else n_pass++;
    n_checks++;
    if (r_mosi_ones !== 0) $display("FAIL high_mosi_zero: got %0d ones want 0", r_mosi_ones);
    else n_pass++;
    n_checks++;
    if (r_cs_low !== 136) $display("FAIL high_cs_low: got %0d want 136", r_cs_low);
    else n_pass++;
    n_checks++;
    if (r_setup_gap < 4) $display("FAIL high_cs_setup: got %0d want >=4", r_setup_gap);
    else n_pass++;
    n_checks++;
    if (r_hold_gap < 4) $display("FAIL high_cs_hold: got %0d want >=4", r_hold_gap);
    else n_pass++;
    n_checks++;
    if (r_rises !== 16) $display("FAIL high_rises: got %0d want 16", r_rises);
    else n_pass++;
    miso_loop = 1'b1;
  endtask

  task automatic test_ignore_start();
    miso_loop = 1'b1;
    run_xfer(16'h1234, 1'b1);
    n_checks++;
    if (r_valid_cnt !== 1) $display("FAIL ignore_valid_count: got %0d want 1", r_valid_cnt);
    else n_pass++;
    n_checks++;
    if (r_rx !== 16'h1234) $display("FAIL ignore_rx_data: got %h want 1234", r_rx);
    else n_pass++;
    n_checks++;
    if (r_seq !== SEQ_1234) $display("FAIL ignore_mosi_seq: got %h want %h", r_seq, SEQ_1234);
    else n_pass++;
    n_checks++;
    if (r_cs_low !== 136) $display("FAIL ignore_cs_low: got %0d want 136", r_cs_low);
    else n_pass++;
    n_checks++;
    if (bus.spi_ready !== 1'b1 || bus.spi_cs_n !== 1'b1)
      $display("FAIL ignore_end_idle: got ready=%b cs_n=%b want 1/1", bus.spi_ready, bus.spi_cs_n);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int valid_seen;
    int cs_low_seen;
    miso_loop = 1'b1;
    @(negedge clk);
    bus.spi_start = 1'b1;
    bus.tx_data   = 16'hFFFF;
    @(negedge clk);
    bus.spi_start = 1'b0;
    for (int i = 1; i < 50; i++) @(negedge clk);
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.spi_cs_n !== 1'b1) $display("FAIL midrst_cs_n: got %b want 1", bus.spi_cs_n);
    else n_pass++;
    n_checks++;
    if (bus.spi_sclk !== 1'b0) $display("FAIL midrst_sclk: got %b want 0", bus.spi_sclk);
    else n_pass++;
    n_checks++;
    if (bus.spi_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", bus.spi_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    valid_seen  = 0;
    cs_low_seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.rx_valid) valid_seen++;
      if (!bus.spi_cs_n) cs_low_seen++;
    end
    n_checks++;
    if (valid_seen !== 0) $display("FAIL midrst_no_valid: got %0d pulses want 0", valid_seen);
    else n_pass++;
    n_checks++;
    if (cs_low_seen !== 0) $display("FAIL midrst_cs_idle: got %0d low cycles want 0", cs_low_seen);
    else n_pass++;
    n_checks++;
    if (bus.rx_data !== 16'h0000) $display("FAIL midrst_rx_data: got %h want 0000", bus.rx_data);
    else n_pass++;
    run_xfer(16'h3C96, 1'b0);
    n_checks++;
    if (r_rx !== 16'h3C96) $display("FAIL midrst_clean_rx: got %h want 3c96", r_rx);
    else n_pass++;
    n_checks++;
    if (r_ready_low !== 136) $display("FAIL midrst_clean_len: got %0d want 136", r_ready_low);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit seen;
    int cycles;
    miso_loop = 1'b1;
    @(negedge clk);
    bus.spi_start = 1'b1;
    bus.tx_data   = 16'hC0DE;
    @(negedge clk);
    bus.spi_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.rx_valid) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL b2b_first_done: got no rx_valid want one within 200 cycles");
    else n_pass++;
    n_checks++;
    if (bus.rx_data !== 16'hC0DE) $display("FAIL b2b_first_rx: got %h want c0de", bus.rx_data);
    else n_pass++;
    n_checks++;
    if (bus.spi_cs_n !== 1'b1) $display("FAIL b2b_cs_gap_high: got %b want 1", bus.spi_cs_n);
    else n_pass++;
    bus.spi_start = 1'b1;
    bus.tx_data   = 16'h0F0F;
    @(negedge clk);
    bus.spi_start = 1'b0;
    n_checks++;
    if (bus.spi_cs_n !== 1'b0 || bus.spi_ready !== 1'b0)
      $display("FAIL b2b_restart: got cs_n=%b ready=%b want 0/0", bus.spi_cs_n, bus.spi_ready);
    else n_pass++;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.rx_valid) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cycles !== 136)
      $display("FAIL b2b_second_len: got seen=%0d cycles=%0d want 1/136", seen, cycles);
    else n_pass++;
    n_checks++;
    if (bus.rx_data !== 16'h0F0F) $display("FAIL b2b_second_rx: got %h want 0f0f", bus.rx_data);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.rx_valid !== 1'b0) $display("FAIL b2b_valid_one_cycle: got %b want 0", bus.rx_valid);
    else n_pass++;
  endtask

  task automatic test_single_bit();
    miso_loop = 1'b1;
    run_xfer(16'h0001, 1'b0);
    n_checks++;
    if (r_seq !== SEQ_0001) $display("FAIL bit_mosi_seq: got %h want %h", r_seq, SEQ_0001);
    else n_pass++;
    n_checks++;
    if (r_rx !== 16'h0001) $display("FAIL bit_rx_data: got %h want 0001", r_rx);
    else n_pass++;
    n_checks++;
    if (r_rises !== 16) $display("FAIL bit_rises: got %0d want 16", r_rises);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_high();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_single_bit();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_transfer_engine.md
Name: spi_transfer_engine

Overview:
SPI mode-0 controller shift engine; the consumer of the periodic spi_start pulse.
- On a spi_start pulse it runs one full-duplex word transfer on SCLK/CS_N/MOSI/MISO.
- spi_ready is high whenever the engine is idle and able to accept a start.
- Sits between the start-pulse generator (100 MHz domain) and the board-level SPI pins.

Parameters:
DATA_WIDTH, 16, bits per transfer (2..32)
CLK_DIV, 4, clk cycles per SCLK half-period (>=2); 100 MHz / (2*4) = 12.5 MHz SCLK
CNT_W, 8, width of half-period counter; must hold CLK_DIV-1

Ports:
clk  input  1  system clock, 100 MHz
rstn  input  1  asynchronous active-low reset
spi_start  input  1  one-cycle start request; honoured only while spi_ready=1
tx_data  input  DATA_WIDTH  word to transmit; sampled on the accepted spi_start cycle
spi_ready  output  1  engine idle, start accepted
rx_data  output  DATA_WIDTH  last received word; held until next completion
rx_valid  output  1  one-cycle pulse when rx_data updates
spi_cs_n  output  1  chip select, active low
spi_sclk  output  1  serial clock, idle low (CPOL=0)
spi_mosi  output  1  serial data out
spi_miso  input  1  serial data in, assumed stable around SCLK rising edge

Behaviour:
- Reset (async, rstn low) values:
  - spi_ready=1, spi_cs_n=1, spi_sclk=0, spi_mosi=0, rx_valid=0, rx_data=0.
  - FSM returns to IDLE.
  - Applies immediately mid-transfer. The partial word is discarded and there is no rx_valid.
- All outputs are registered.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD.
- IDLE:
  - On spi_start=1 at a clock edge: latch tx_data into the shift register.
  - Set spi_cs_n<=0, spi_ready<=0, spi_mosi<=first bit (MSB), clear the counters, go to CS_SETUP.
  - spi_start while spi_ready=0 is ignored, with no queuing.
- CS_SETUP: hold for CLK_DIV cycles with SCLK low, then go to SHIFT.
- SHIFT:
  - The half-period counter counts 0..CLK_DIV-1; at terminal count spi_sclk toggles.
  - Rising toggle: sample spi_miso into the receive shift register.
  - Falling toggle:
    - Increment the bit counter.
    - If bits remain, drive the next tx bit on spi_mosi.
    - After the DATA_WIDTH-th falling edge, go to CS_HOLD with SCLK low.
  - Exactly DATA_WIDTH rising edges per transfer.
- CS_HOLD:
  - Hold for CLK_DIV cycles.
  - Then in a single edge: spi_cs_n<=1, rx_data<=receive register, rx_valid<=1, spi_ready<=1, go to IDLE.
  - spi_mosi<=0.
- rx_valid is high for exactly one cycle; it deasserts the next cycle.
- Latency: spi_ready is low for exactly (2*DATA_WIDTH+2)*CLK_DIV cycles = 136 at defaults. It is low from the cycle after the accepted start until the completion edge.
- A spi_start coincident with the cycle spi_ready returns high is not accepted. Acceptance requires the registered spi_ready=1.
- Back-to-back: a start accepted in the cycle after completion gives spi_cs_n high for exactly 1 cycle.
- The start generator's ~2001-cycle spacing always exceeds the transfer length at default parameters.
- Bit counter width is $clog2(DATA_WIDTH)+1; there is no wrap inside a transfer.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: transmit LSB first (tx shifts right). Received bits fill from the MSB end so that rx_data bit 0 is the first bit received.
- Undefined (default): MSB first on both MOSI and MISO; rx_data MSB is the first bit received.
- Timing is identical in both builds.

Test Plan:
- Reset: rstn low for 5 cycles -> spi_ready=1, spi_cs_n=1, spi_sclk=0, spi_mosi=0, rx_valid=0, rx_data=0x0000.
- Loopback (miso tied to mosi), tx_data=0xA5C3, one spi_start pulse:
  - 16 SCLK rising edges; MOSI bit sequence 1010_0101_1100_0011.
  - rx_data=0xA5C3 with rx_valid pulsed once.
  - spi_ready low for 136 cycles.
- spi_miso tied 1, tx_data=0x0000 -> rx_data=0xFFFF, MOSI constantly 0. spi_cs_n low for 136 cycles, bracketing all SCLK edges by >=4 clk cycles each side.
- spi_start pulsed 10 and 60 cycles into a transfer with a different tx_data -> ignored: one transfer, one rx_valid, original word sent.
- rstn asserted 50 cycles into a transfer -> spi_cs_n=1 and spi_sclk=0 immediately, no rx_valid. A subsequent start runs a clean full transfer.
- SPI_LSB_FIRST_EN defined, loopback, tx_data=0x0001 -> first MOSI bit 1 then fifteen 0s, rx_data=0x0001.
